sdcard_power_manager: RTL and testbench

SDCARD_POWER_MANAGER -- requirements
Module: sdcard_power_manager

---
 rtl/sdcard_pkg.sv | 35 +++
 rtl/sdcard_pm_timer.sv | 32 +++
 rtl/sdcard_power_manager.sv | 153 +++++++++++++++
 tb/tb_sdcard_power_manager.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/sdcard_pkg.sv
// sdcard_pkg: shared types and constants for the SD card power manager.
//   PS_*           power_state_o request encodings to the power controller
//   pm_state_t     power manager FSM states
//   WAIT_GOOD_MAX  last wait count before power-up is declared failed
//   RECOVER_HOLD   cycles spent in RECOVER before retrying
//   MAX_RETRY      retry counter saturation value
package sdcard_pkg;

    localparam logic [1:0] PS_ACTIVE = 2'b00;
    localparam logic [1:0] PS_IDLE   = 2'b01;
    localparam logic [1:0] PS_SLEEP  = 2'b10;
    localparam logic [1:0] PS_DOWN   = 2'b11;

    localparam int WAIT_GOOD_MAX = 1023;
    localparam int RECOVER_HOLD  = 64;
    localparam int MAX_RETRY     = 3;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_WAIT_GOOD,
        ST_ACTIVE,
        ST_IDLE,
        ST_SLEEP,
        ST_RECOVER,
        ST_LOCKED
    } pm_state_t;

    // Power request seen by the controller in each FSM state.
    function automatic logic [1:0] ps_encode(input pm_state_t s);
        return (s == ST_WAIT_GOOD || s == ST_ACTIVE) ? PS_ACTIVE :
               (s == ST_IDLE)                        ? PS_IDLE   :
               (s == ST_SLEEP)                       ? PS_SLEEP  : PS_DOWN;
    endfunction

endpackage

// File: rtl/sdcard_pm_timer.sv
// sdcard_pm_timer: 16-bit clearable saturating inactivity counter with expiry compare.
//   PCLK_i     clock
//   PRESETn_i  asynchronous active-low reset
//   clr_i      clear the count (wins over en_i)
//   en_i       count this cycle
//   limit_i    expiry threshold; 0 disables expiry
//   expired_o  count has reached or passed a nonzero limit
module sdcard_pm_timer
(
    input  logic        PCLK_i,
    input  logic        PRESETn_i,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [15:0] limit_i,
    output logic        expired_o
);

    logic [15:0] count;

    always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
        if (!PRESETn_i)
            count <= '0;
        else if (clr_i)
            count <= '0;
        else if (en_i && count != 16'hFFFF)
            count <= count + 16'd1;
    end

    // >= rather than == so a limit lowered below the running count still expires.
    assign expired_o = (limit_i != 16'd0) && (count >= limit_i);

endmodule

// File: rtl/sdcard_power_manager.sv
// sdcard_power_manager: SD card power sequencing FSM with idle/sleep, fault recovery and lockout.
//   PCLK_i, PRESETn_i        clock, asynchronous active-low reset
//   activity_i               command/data activity this cycle
//   sw_pd_req_i              software power-down request (level)
//   sw_vsel_i                requested voltage code
//   idle_timeout_i           inactivity cycles before IDLE (0 disables)
//   sleep_timeout_i          further idle cycles before SLEEP (0 disables)
//   power_good_i/fault_i     status from the power controller
//   power_state_o            request: ACTIVE 00, IDLE 01, SLEEP 10, DOWN 11
//   voltage_sel_o            applied voltage code
//   clk_enable_o             card clock enable
//   pm_irq_o                 one-cycle event pulse (powered up, recover, locked)
//   retry_cnt_o              failed power-up attempts, saturating
//   pm_locked_o              retries exhausted; only a power-down request exits
// Build option: define SDCARD_PM_AUTO_SLEEP_EN to let IDLE fall into SLEEP.
module sdcard_power_manager
    import sdcard_pkg::*;
(
    input  logic        PCLK_i,
    input  logic        PRESETn_i,
    input  logic        activity_i,
    input  logic        sw_pd_req_i,
    input  logic [3:0]  sw_vsel_i,
    input  logic [15:0] idle_timeout_i,
    input  logic [15:0] sleep_timeout_i,
    input  logic        power_good_i,
    input  logic        power_fault_i,
    output logic [1:0]  power_state_o,
    output logic [3:0]  voltage_sel_o,
    output logic        clk_enable_o,
    output logic        pm_irq_o,
    output logic [1:0]  retry_cnt_o,
    output logic        pm_locked_o
);

    pm_state_t   state, state_n;
    logic [3:0]  vsel_n;
    logic [1:0]  retry_n;
    logic        irq_n;
    logic [9:0]  wait_cnt;
    logic [5:0]  hold_cnt;
    logic        tmr_expired;
    logic        tmr_clr;
    logic        sleep_hit;

    // One timer serves both ACTIVE (idle timeout) and IDLE (sleep timeout);
    // every state change restarts it.
    sdcard_pm_timer u_timer (
        .PCLK_i    (PCLK_i),
        .PRESETn_i (PRESETn_i),
        .clr_i     (tmr_clr),
        .en_i      (state == ST_ACTIVE || state == ST_IDLE),
        .limit_i   (state == ST_IDLE ? sleep_timeout_i : idle_timeout_i),
        .expired_o (tmr_expired)
    );

`ifdef SDCARD_PM_AUTO_SLEEP_EN
    assign sleep_hit = tmr_expired;
`else
    assign sleep_hit = 1'b0;
`endif

    always_comb begin
        state_n = state;
        vsel_n  = voltage_sel_o;
        retry_n = retry_cnt_o;
        if (sw_pd_req_i) begin
            state_n = ST_OFF;
            retry_n = '0;
        end else begin
            case (state)
                ST_OFF: begin
                    state_n = ST_WAIT_GOOD;
                    vsel_n  = sw_vsel_i;
                end
                ST_WAIT_GOOD: begin
                    if (power_fault_i)
                        state_n = ST_RECOVER;
                    else if (power_good_i) begin
                        state_n = ST_ACTIVE;
                        retry_n = '0;
                    end else if (wait_cnt == 10'(WAIT_GOOD_MAX))
                        state_n = ST_RECOVER;
                end
                ST_ACTIVE: begin
                    if (power_fault_i)
                        state_n = ST_RECOVER;
                    else if (sw_vsel_i != voltage_sel_o) begin
                        state_n = ST_WAIT_GOOD;
                        vsel_n  = sw_vsel_i;
                    end else if (!activity_i && tmr_expired)
                        state_n = ST_IDLE;
                end
                ST_IDLE: begin
                    if (power_fault_i)
                        state_n = ST_RECOVER;
                    else if (activity_i)
                        state_n = ST_ACTIVE;
                    else if (sleep_hit)
                        state_n = ST_SLEEP;
                end
                ST_SLEEP: begin
                    // The card is unpowered here, so waking needs a fresh power-good.
                    if (power_fault_i)
                        state_n = ST_RECOVER;
                    else if (activity_i)
                        state_n = ST_WAIT_GOOD;
                end
                ST_RECOVER: begin
                    if (hold_cnt == 6'(RECOVER_HOLD - 1)) begin
                        retry_n = (retry_cnt_o == 2'(MAX_RETRY)) ? retry_cnt_o : retry_cnt_o + 2'd1;
                        state_n = (retry_cnt_o == 2'(MAX_RETRY - 1)) ? ST_LOCKED : ST_WAIT_GOOD;
                    end
                end
                default: state_n = state;
            endcase
        end
    end

    assign irq_n = (state_n != state) &&
                   (state_n == ST_RECOVER || state_n == ST_LOCKED ||
                    (state_n == ST_ACTIVE && state == ST_WAIT_GOOD));

    assign tmr_clr = (state_n != state) || activity_i;

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
        if (!PRESETn_i) begin
            state         <= ST_OFF;
            power_state_o <= PS_DOWN;
            voltage_sel_o <= '0;
            clk_enable_o  <= 1'b0;
            pm_irq_o      <= 1'b0;
            retry_cnt_o   <= '0;
            pm_locked_o   <= 1'b0;
            wait_cnt      <= '0;
            hold_cnt      <= '0;
        end else begin
            state         <= state_n;
            power_state_o <= ps_encode(state_n);
            voltage_sel_o <= vsel_n;
            clk_enable_o  <= (state_n == ST_ACTIVE);
            pm_irq_o      <= irq_n;
            retry_cnt_o   <= retry_n;
            pm_locked_o   <= (state_n == ST_LOCKED);
            wait_cnt      <= (state == ST_WAIT_GOOD && state_n == ST_WAIT_GOOD) ?
                             ((wait_cnt == 10'(WAIT_GOOD_MAX)) ? wait_cnt : wait_cnt + 10'd1) : '0;
            hold_cnt      <= (state == ST_RECOVER && state_n == ST_RECOVER) ?
                             ((hold_cnt == 6'(RECOVER_HOLD - 1)) ? hold_cnt : hold_cnt + 6'd1) : '0;
        end
    end

endmodule

// File: tb/tb_sdcard_power_manager.sv
// tb_sdcard_power_manager: directed table-driven and sequence checks for sdcard_power_manager.
module tb_sdcard_power_manager;

    logic        PCLK_i = 1'b0;
    logic        PRESETn_i = 1'b0;
    logic        activity_i = 1'b0;
    logic        sw_pd_req_i = 1'b0;
    logic [3:0]  sw_vsel_i = 4'h1;
    logic [15:0] idle_timeout_i = 16'd3;
    logic [15:0] sleep_timeout_i = 16'd0;
    logic        power_good_i = 1'b0;
    logic        power_fault_i = 1'b0;
    logic [1:0]  power_state_o;
    logic [3:0]  voltage_sel_o;
    logic        clk_enable_o;
    logic        pm_irq_o;
    logic [1:0]  retry_cnt_o;
    logic        pm_locked_o;

    int errors = 0;
    int checks = 0;
    int n;

    always #5 PCLK_i = ~PCLK_i;

    sdcard_power_manager dut (
        .PCLK_i          (PCLK_i),
        .PRESETn_i       (PRESETn_i),
        .activity_i      (activity_i),
        .sw_pd_req_i     (sw_pd_req_i),
        .sw_vsel_i       (sw_vsel_i),
        .idle_timeout_i  (idle_timeout_i),
        .sleep_timeout_i (sleep_timeout_i),
        .power_good_i    (power_good_i),
        .power_fault_i   (power_fault_i),
        .power_state_o   (power_state_o),
        .voltage_sel_o   (voltage_sel_o),
        .clk_enable_o    (clk_enable_o),
        .pm_irq_o        (pm_irq_o),
        .retry_cnt_o     (retry_cnt_o),
        .pm_locked_o     (pm_locked_o)
    );

    // Observed output bundle: {ps[1:0], clk_en, irq, retry[1:0], locked, vsel[3:0]}.
    logic [10:0] obs;
    assign obs = {power_state_o, clk_enable_o, pm_irq_o, retry_cnt_o, pm_locked_o, voltage_sel_o};

    typedef struct packed {
        logic       pd;
        logic [3:0] vsel;
        logic       act;
        logic       good;
        logic       fault;
        logic [10:0] exp;
    } vec_t;

    vec_t tbl [26];

    function automatic vec_t mk(input logic pd, input logic [3:0] vsel, input logic act,
                                input logic good, input logic fault, input logic [1:0] ps,
                                input logic clk, input logic irq, input logic [1:0] retry,
                                input logic lock, input logic [3:0] vo);
        vec_t v;
        v.pd = pd; v.vsel = vsel; v.act = act; v.good = good; v.fault = fault;
        v.exp = {ps, clk, irq, retry, lock, vo};
        return v;
    endfunction

    task automatic tick();
        @(posedge PCLK_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    initial begin
        // One row per clock: inputs applied, then outputs after the edge.
        tbl[0]  = mk(0, 4'h1, 0, 0, 0, 2'b00, 0, 0, 2'd0, 0, 4'h1); // OFF -> WAIT_GOOD, latch 1
        tbl[1]  = mk(0, 4'h1, 0, 0, 0, 2'b00, 0, 0, 2'd0, 0, 4'h1);
        tbl[2]  = mk(0, 4'h1, 0, 1, 0, 2'b00, 1, 1, 2'd0, 0, 4'h1); // good -> ACTIVE + irq
        tbl[3]  = mk(0, 4'h1, 0, 0, 0, 2'b00, 1, 0, 2'd0, 0, 4'h1);
        tbl[4]  = mk(0, 4'h1, 0, 0, 0, 2'b00, 1, 0, 2'd0, 0, 4'h1);
        tbl[5]  = mk(0, 4'h1, 0, 0, 0, 2'b00, 1, 0, 2'd0, 0, 4'h1);
        tbl[6]  = mk(0, 4'h1, 0, 0, 0, 2'b01, 0, 0, 2'd0, 0, 4'h1); // count 3 -> IDLE
        tbl[7]  = mk(0, 4'h1, 1, 0, 0, 2'b00, 1, 0, 2'd0, 0, 4'h1); // activity -> ACTIVE
        tbl[8]  = mk(0, 4'h1, 1, 0, 0, 2'b00, 1, 0, 2'd0, 0, 4'h1);
        tbl[9]  = mk(0, 4'h2, 0, 0, 0, 2'b00, 0, 0, 2'd0, 0, 4'h2); // vsel change -> WAIT_GOOD
        tbl[10] = mk(0, 4'h2, 0, 1, 0, 2'b00, 1, 1, 2'd0, 0, 4'h2);
        tbl[11] = mk(0, 4'h2, 1, 0, 1, 2'b11, 0, 1, 2'd0, 0, 4'h2); // fault beats activity
        tbl[12] = mk(0, 4'h2, 0, 0, 0, 2'b11, 0, 0, 2'd0, 0, 4'h2);
        tbl[13] = mk(1, 4'h2, 0, 0, 0, 2'b11, 0, 0, 2'd0, 0, 4'h2); // power-down -> OFF
        tbl[14] = mk(1, 4'h5, 0, 0, 0, 2'b11, 0, 0, 2'd0, 0, 4'h2); // vsel not latched in OFF w/ pd
        tbl[15] = mk(0, 4'h5, 0, 0, 0, 2'b00, 0, 0, 2'd0, 0, 4'h5);
        tbl[16] = mk(0, 4'h5, 0, 1, 1, 2'b11, 0, 1, 2'd0, 0, 4'h5); // fault beats good
        tbl[17] = mk(1, 4'h5, 0, 0, 0, 2'b11, 0, 0, 2'd0, 0, 4'h5);
        tbl[18] = mk(0, 4'h5, 0, 0, 0, 2'b00, 0, 0, 2'd0, 0, 4'h5);
        tbl[19] = mk(0, 4'h5, 0, 1, 0, 2'b00, 1, 1, 2'd0, 0, 4'h5);
        tbl[20] = mk(0, 4'h5, 0, 0, 0, 2'b00, 1, 0, 2'd0, 0, 4'h5);
        tbl[21] = mk(0, 4'h5, 0, 0, 0, 2'b00, 1, 0, 2'd0, 0, 4'h5);
        tbl[22] = mk(0, 4'h5, 0, 0, 0, 2'b00, 1, 0, 2'd0, 0, 4'h5);
        tbl[23] = mk(0, 4'h5, 0, 0, 0, 2'b01, 0, 0, 2'd0, 0, 4'h5);
        tbl[24] = mk(0, 4'h5, 1, 0, 1, 2'b11, 0, 1, 2'd0, 0, 4'h5); // IDLE fault+activity -> RECOVER
        tbl[25] = mk(1, 4'h5, 0, 0, 0, 2'b11, 0, 0, 2'd0, 0, 4'h5);

        // Reset values while held in reset.
        tick();
        tick();
        chk("reset_outputs", 32'(obs), 32'({2'b11, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0}));
        PRESETn_i = 1'b1;

        foreach (tbl[i]) begin
            sw_pd_req_i   = tbl[i].pd;
            sw_vsel_i     = tbl[i].vsel;
            activity_i    = tbl[i].act;
            power_good_i  = tbl[i].good;
            power_fault_i = tbl[i].fault;
            tick();
            chk($sformatf("row%0d", i), 32'(obs), 32'(tbl[i].exp));
        end
        activity_i = 0; power_good_i = 0; power_fault_i = 0;

        // Power-up with good arriving 5 cycles into WAIT_GOOD.
        sw_pd_req_i = 0; sw_vsel_i = 4'h1;
        tick();
        for (int k = 0; k < 4; k++) tick();
        power_good_i = 1;
        tick();
        chk("powerup_state", 32'(obs), 32'({2'b00, 1'b1, 1'b1, 2'd0, 1'b0, 4'h1}));
        power_good_i = 0;
        tick();
        chk("powerup_irq_single", 32'(pm_irq_o), 32'd0);

        // Counter reaches 100 after 100 idle edges; IDLE is registered on the next edge.
        idle_timeout_i = 16'd100;
        activity_i = 1;
        tick();
        activity_i = 0;
        n = 0;
        do begin tick(); n++; end while (power_state_o != 2'b01 && n < 300);
        chk("active_to_idle_cycles", 32'(n), 32'd101);
        activity_i = 1;
        tick();
        activity_i = 0;
        chk("idle_wake_state", 32'(power_state_o), 32'd0);
        chk("idle_wake_clk", 32'(clk_enable_o), 32'd1);

        // Timeout lowered below the running count expires at once.
        for (int k = 0; k < 50; k++) tick();
        chk("still_active_at_50", 32'(power_state_o), 32'd0);
        idle_timeout_i = 16'd20;
        tick();
        chk("lowered_timeout_idle", 32'(power_state_o), 32'd1);
        idle_timeout_i = 16'd100;

        // Sleep from IDLE (macro dependent).
        sleep_timeout_i = 16'd50;
        n = 0;
        do begin tick(); n++; end while (power_state_o != 2'b10 && n < 120);
`ifdef SDCARD_PM_AUTO_SLEEP_EN
        chk("idle_to_sleep_cycles", 32'(n), 32'd51);
        activity_i = 1;
        tick();
        activity_i = 0;
        chk("sleep_wake_wait_good", 32'({power_state_o, clk_enable_o}), 32'({2'b00, 1'b0}));
`else
        chk("no_sleep_stays_idle", 32'(power_state_o), 32'd1);
`endif
        sleep_timeout_i = 16'd0;
        sw_pd_req_i = 1;
        tick();
        chk("pd_to_off", 32'(power_state_o), 32'd3);

        // Three failed power-ups: WAIT_GOOD 1024 cycles, RECOVER 64 cycles each.
        sw_pd_req_i = 0;
        power_good_i = 0;
        tick();
        for (int a = 0; a < 3; a++) begin
            n = 0;
            do begin tick(); n++; end while (power_state_o != 2'b11 && n < 1100);
            chk($sformatf("wait_good_expiry%0d", a), 32'(n), 32'd1024);
            chk($sformatf("recover_irq%0d", a), 32'(pm_irq_o), 32'd1);
            n = 0;
            if (a < 2) begin
                do begin tick(); n++; end while (power_state_o != 2'b00 && n < 100);
                chk($sformatf("recover_hold%0d", a), 32'(n), 32'd64);
                chk($sformatf("retry_after%0d", a), 32'(retry_cnt_o), 32'(a + 1));
            end else begin
                do begin tick(); n++; end while (!pm_locked_o && n < 100);
                chk("lock_hold", 32'(n), 32'd64);
                chk("locked_outputs", 32'(obs), 32'({2'b11, 1'b0, 1'b1, 2'd3, 1'b1, 4'h1}));
            end
        end
        power_good_i = 1;
        for (int k = 0; k < 5; k++) tick();
        chk("locked_holds", 32'({power_state_o, pm_locked_o, pm_irq_o}), 32'({2'b11, 1'b1, 1'b0}));
        sw_pd_req_i = 1;
        tick();
        chk("locked_pd_exit", 32'({power_state_o, pm_locked_o, retry_cnt_o}), 32'({2'b11, 1'b0, 2'd0}));

        // Asynchronous reset mid-operation.
        sw_pd_req_i = 0; sw_vsel_i = 4'h7;
        tick();
        tick();
        chk("pre_reset_active", 32'({power_state_o, clk_enable_o}), 32'({2'b00, 1'b1}));
        #2 PRESETn_i = 1'b0;
        #1;
        chk("async_reset", 32'(obs), 32'({2'b11, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0}));
        #10 PRESETn_i = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
